// File: rtl/ram_zweitor_pkg.sv
// ram_pkg: shared state type and collision policy constants for ram_zweitor
package ram_pkg;
    typedef enum logic {LOESCHEN, BEREIT} zustand_t;
    localparam int KOLLISION_ALT = 0;
    localparam int KOLLISION_NEU = 1;
endpackage

// File: rtl/ram_zweitor_lesestufe.sv
// ram_lesestufe: per-port read output pipeline of depth 1 or 2, zeroing out-of-range reads
module ram_lesestufe #(
    parameter int WORDSIZE = 32,
    parameter int LATENZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                anfrage,
    input  logic                ausserhalb,
    input  logic [WORDSIZE-1:0] wort,
    output logic                gueltig,
    output logic [WORDSIZE-1:0] daten_raus
);
    logic                v1;
    logic [WORDSIZE-1:0] d1;
    // first stage: capture accepted read, hold data between reads
    always_ff @(posedge clk)
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= anfrage;
            d1 <= anfrage ? (ausserhalb ? '0 : wort) : d1;
        end
    if (LATENZ == 2) begin : g_zwei
        logic                v2;
        logic [WORDSIZE-1:0] d2;
        // second stage: one extra cycle of delay, same hold behaviour
        always_ff @(posedge clk)
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                d2 <= v1 ? d1 : d2;
            end
        assign gueltig = v2;
        assign daten_raus = d2;
    end else begin : g_eins
        assign gueltig = v1;
        assign daten_raus = d1;
    end
endmodule

// File: rtl/ram_zweitor.sv
// ram_zweitor: dual-port word RAM, byte-masked port B writes, collision policy, clear-on-reset
module ram_zweitor
    import ram_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int WORDS = 256,
    parameter int LATENZ = 1,
    parameter int KOLLISION = 0,
    parameter int LOESCHEN = 1,
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int BW = WORDSIZE / 8
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic                Bereit,
    output logic                Fehler,
    input  logic                A_Anfrage,
    input  logic [AW-1:0]       A_Adresse,
    output logic                A_Gueltig,
    output logic [WORDSIZE-1:0] A_DatenRaus,
    input  logic                B_Anfrage,
    input  logic                B_SchreibenAn,
    input  logic [BW-1:0]       B_Bytemaske,
    input  logic [AW-1:0]       B_Adresse,
    input  logic [WORDSIZE-1:0] B_DatenRein,
    output logic                B_Gueltig,
    output logic [WORDSIZE-1:0] B_DatenRaus
);
    localparam logic [AW:0]   GRENZE = (AW + 1)'(WORDS);
    localparam logic [AW-1:0] LETZTE = AW'(WORDS - 1);
    logic [WORDSIZE-1:0] daten [WORDS];
    zustand_t            zustand, naechster;
    logic [AW-1:0]       zaehler;
    logic                loeschen_an, a_an, b_an, a_aus, b_aus, b_schreib, kollidiert;
    logic [WORDSIZE-1:0] a_alt, b_alt, b_neu, a_wort;
    // clear FSM state register and clear address counter
    always_ff @(posedge Clock)
        if (Reset) begin
            zustand <= (LOESCHEN != 0) ? ram_pkg::LOESCHEN : BEREIT;
            zaehler <= '0;
        end else begin
            zustand <= naechster;
            zaehler <= loeschen_an ? zaehler + 1'b1 : zaehler;
        end
    // leave clearing once the last word has been zeroed
    always_comb
        naechster = (zustand == ram_pkg::LOESCHEN && zaehler == LETZTE) ? BEREIT : zustand;
    // FSM outputs
    always_comb begin
        Bereit = zustand == BEREIT;
        loeschen_an = zustand == ram_pkg::LOESCHEN;
    end
    assign a_an = Bereit & A_Anfrage & ~Reset;
    assign b_an = Bereit & B_Anfrage & ~Reset;
    assign a_aus = {1'b0, A_Adresse} >= GRENZE;
    assign b_aus = {1'b0, B_Adresse} >= GRENZE;
    assign b_schreib = b_an & B_SchreibenAn & ~b_aus;
    assign a_alt = a_aus ? '0 : daten[A_Adresse];
    assign b_alt = b_aus ? '0 : daten[B_Adresse];
    assign kollidiert = KOLLISION == KOLLISION_NEU && b_schreib && A_Adresse == B_Adresse;
    assign a_wort = kollidiert ? b_neu : a_alt;
    // merge enabled bytes of the write data over the stored word
    always_comb begin
        b_neu = b_alt;
        for (int i = 0; i < BW; i++)
            b_neu[8*i +: 8] = B_Bytemaske[i] ? B_DatenRein[8*i +: 8] : b_alt[8*i +: 8];
    end
    // array write port: clear sequencer has priority, then port B writes
    always_ff @(posedge Clock)
        if (!Reset) begin
            if (loeschen_an)
                daten[zaehler] <= '0;
            else if (b_schreib)
                daten[B_Adresse] <= b_neu;
        end
    // single error pulse for any accepted out-of-range request
    always_ff @(posedge Clock)
        if (Reset)
            Fehler <= 1'b0;
        else
            Fehler <= (a_an & a_aus) | (b_an & b_aus);
    ram_lesestufe #(.WORDSIZE(WORDSIZE), .LATENZ(LATENZ)) u_lese_a (
        .clk(Clock), .rst(Reset), .anfrage(a_an), .ausserhalb(a_aus), .wort(a_wort),
        .gueltig(A_Gueltig), .daten_raus(A_DatenRaus)
    );
    ram_lesestufe #(.WORDSIZE(WORDSIZE), .LATENZ(LATENZ)) u_lese_b (
        .clk(Clock), .rst(Reset), .anfrage(b_an & ~B_SchreibenAn), .ausserhalb(b_aus), .wort(b_alt),
        .gueltig(B_Gueltig), .daten_raus(B_DatenRaus)
    );
endmodule
